// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared definitions for the sequential multiplier slice.
//                Holds the default operand width and the controller state
//                encoding used by seq_mult_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
package mult_pkg;

    // Default operand width; the product is twice this wide.
    localparam int unsigned c_WIDTH_DEFAULT = 32;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/cla_add.sv
`default_nettype none
// ============================================================================
//  Module      : cla_add
//  Description : WIDTH-bit parallel-prefix (Kogge-Stone) carry-lookahead
//                adder with carry-in and carry-out.
//  Ports       : i_a, i_b  - addends (WIDTH bits)
//                i_cin     - carry in
//                o_sum     - sum (WIDTH bits)
//                o_cout    - carry out of the most significant bit
//  Revision    : 1.0  initial release
// ============================================================================
module cla_add #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    localparam logic [WIDTH-1:0] c_ONES = '1;

    logic [WIDTH-1:0] w_p0;     // bitwise propagate, reused for the sum
    logic [WIDTH-1:0] w_gk;     // group generate over [i:0] once the prefix completes
    logic [WIDTH-1:0] w_pk;     // group propagate over [i:0] once the prefix completes
    logic [WIDTH:0]   w_carry;  // w_carry[i] is the carry into bit i

    assign w_p0 = i_a ^ i_b;

    // Prefix tree: each pass doubles the span each (G,P) pair covers. Bits
    // below the span distance already reach bit 0, so they pass through
    // unchanged (zero-fill for G, one-fill for P).
    always_comb begin
        w_gk = i_a & i_b;
        w_pk = w_p0;
        for (int unsigned d = 1; d < WIDTH; d = d * 2) begin
            w_gk = w_gk | (w_pk & (w_gk << d));
            w_pk = w_pk & ((w_pk << d) | (c_ONES >> (WIDTH - d)));
        end
    end

    assign w_carry = {w_gk | (w_pk & {WIDTH{i_cin}}), i_cin};
    assign o_sum   = w_p0 ^ w_carry[WIDTH-1:0];
    assign o_cout  = w_carry[WIDTH];

endmodule : cla_add
`default_nettype wire

// File: rtl/seq_mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult_ctrl
//  Description : Unsigned radix-2 shift-add sequential multiplier. One
//                multiplier bit is retired per RUN cycle through a single
//                shared carry-lookahead adder.
//  Ports       : clk   - clock, all state updates on the rising edge
//                rst   - synchronous active-high reset
//                start - operation request, sampled only while ready=1
//                a, b  - multiplicand / multiplier (WIDTH bits, unsigned)
//                ready - a new start will be accepted
//                done  - one-cycle pulse, p valid for the last operation
//                p     - registered product (2*WIDTH bits)
//  Options     : SEQ_MULT_EARLY_TERM_EN - when defined, the operation ends
//                as soon as the unprocessed multiplier bits are all zero.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_mult_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = c_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int unsigned c_CNT_W = $clog2(WIDTH + 1);

    state_t               r_state;
    logic [WIDTH-1:0]     r_mcand;   // captured multiplicand
    logic [WIDTH-1:0]     r_acc_hi;  // upper half of the running product
    logic [WIDTH-1:0]     r_mq;      // unprocessed multiplier / lower product bits
    logic [c_CNT_W-1:0]   r_cnt;     // multiplier bits still to process
    logic                 r_ready;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_p;

    logic [WIDTH-1:0]     w_sum;
    logic                 w_cout;
    logic [WIDTH-1:0]     w_add_s;
    logic                 w_add_c;
    logic [2*WIDTH-1:0]   w_prod_nxt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic                 w_finish;
    logic [2*WIDTH-1:0]   w_p_nxt;

    cla_add #(
        .WIDTH (WIDTH)
    ) u_cla_add (
        .i_a    (r_acc_hi),
        .i_b    (r_mcand),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // One shift-add step: add the multiplicand when the current multiplier
    // bit is set, then shift {carry,sum,mq} right by one. The carry lands
    // in the top bit, so nothing is lost.
    assign w_add_s    = r_mq[0] ? w_sum : r_acc_hi;
    assign w_add_c    = r_mq[0] & w_cout;
    assign w_prod_nxt = {w_add_c, w_add_s, r_mq[WIDTH-1:1]};
    assign w_cnt_nxt  = r_cnt - 1'b1;

`ifdef SEQ_MULT_EARLY_TERM_EN
    // The low w_cnt_nxt bits of the shifted mq are the multiplier bits not
    // yet retired. If they are all zero the remaining steps would only
    // shift, so the product is the register pair shifted by that count.
    localparam logic [WIDTH-1:0] c_ONES = '1;
    logic [WIDTH-1:0] w_rem_mask;
    assign w_rem_mask = ~(c_ONES << w_cnt_nxt);
    assign w_finish   = ((w_prod_nxt[WIDTH-1:0] & w_rem_mask) == '0);
    assign w_p_nxt    = w_prod_nxt >> w_cnt_nxt;
`else
    assign w_finish   = (w_cnt_nxt == '0);
    assign w_p_nxt    = w_prod_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_acc_hi <= '0;
            r_mq     <= '0;
            r_cnt    <= '0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_p      <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_mcand  <= a;
                        r_mq     <= b;
                        r_acc_hi <= '0;
                        r_cnt    <= c_CNT_W'(WIDTH);
                        r_ready  <= 1'b0;
                        r_state  <= RUN;
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                RUN: begin
                    // start is deliberately not looked at here.
                    r_acc_hi <= w_prod_nxt[2*WIDTH-1:WIDTH];
                    r_mq     <= w_prod_nxt[WIDTH-1:0];
                    r_cnt    <= w_cnt_nxt;
                    if (w_finish) begin
                        r_p     <= w_p_nxt;
                        r_ready <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign done  = r_done;
    assign p     = r_p;

endmodule : seq_mult_ctrl
`default_nettype wire

// File: tb/tb_seq_mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_mult_ctrl
//  Description : Self-checking bench for seq_mult_ctrl (WIDTH=32). Issued
//                operations push {expected product, expected done cycle}
//                onto a queue; a monitor pops and compares on every done.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_mult_ctrl;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;

    typedef struct {
        logic [2*W-1:0] p;
        int             due;   // cyc value seen at the negedge where done is high
    } sb_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           ready;
    logic           done;
    logic [2*W-1:0] p;

    int  cyc = 0;
    int  n_total = 0;
    int  n_pass = 0;
    int  last_done_cyc = 0;
    sb_t sb[$];
    vec_t vecs[12];

    seq_mult_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Cycles from the accepting edge to the edge that samples done=1.
    function automatic int lat_of(input logic [W-1:0] bb);
`ifdef SEQ_MULT_EARLY_TERM_EN
        int n;
        n = 1;
        for (int i = 0; i < W; i++)
            if (bb[i]) n = i + 1;
        return n + 1;
`else
        return W + 1;
`endif
    endfunction

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name, input int waited);
        n_total++;
        $display("FAIL %s: event did not occur within %0d cycles (t=%0t)", name, waited, $time);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        sb_t e;
        if (done === 1'b1) begin
            last_done_cyc = cyc;
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: done=1 with p=%h, expected no done (t=%0t)", p, $time);
            end else begin
                e = sb.pop_front();
                chk("product", p, e.p);
                chk("done_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    // Issue one operation and return at the negedge after it is accepted.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [2*W-1:0] pe);
        int w;
        w = 0;
        @(negedge clk);
        while (ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (ready !== 1'b1) fail_now("issue_ready", w);
        start = 1'b1;
        a = ia;
        b = ib;
        @(posedge clk);
        #1;
        sb.push_back('{p: pe, due: cyc + lat_of(ib) - 1});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int w;
        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (sb.size() != 0) begin
            fail_now(name, w);
            sb.delete();
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int first_done;
        int d;
        logic [W-1:0] ra, rb;

        vecs[0]  = '{32'd3,        32'd5,        64'd15};
        vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
        vecs[2]  = '{32'd0,        32'd0,        64'd0};
        vecs[3]  = '{32'd1,        32'h80000000, 64'h00000000_80000000};
        vecs[4]  = '{32'd7,        32'd1,        64'd7};
        vecs[5]  = '{32'hDEADBEEF, 32'd0,        64'd0};
        vecs[6]  = '{32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF};
        vecs[7]  = '{32'hFFFFFFFF, 32'd2,        64'h00000001_FFFFFFFE};
        vecs[8]  = '{32'h00010000, 32'h00010000, 64'h00000001_00000000};
        vecs[9]  = '{32'h80000000, 32'h80000000, 64'h40000000_00000000};
        vecs[10] = '{32'd10,       32'd10,       64'd100};
        vecs[11] = '{32'hAAAAAAAA, 32'd3,        64'h00000001_FFFFFFFE};

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_ready", 64'(ready), 64'd1);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_p", p, 64'd0);

        // Single operation; ready must stay low for latency-1 cycles.
        issue(32'd3, 32'd5, 64'd15);
        cnt = 0;
        while (ready !== 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        chk("ready_low_cycles", 64'(cnt), 64'(lat_of(32'd5) - 1));
        wait_idle("op_3x5");

        // Table vectors.
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].p);
            wait_idle("table_op");
        end

        // A start during RUN is ignored.
        issue(32'd2, 32'd2, 64'd4);
        d = (lat_of(32'd2) > 6) ? 4 : 0;
        repeat (d) @(negedge clk);
        chk("ignore_ready_low", 64'(ready), 64'd0);
        start = 1'b1;
        a = 32'd9;
        b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        wait_idle("ignore_op");
        repeat (4) @(negedge clk);
        chk("ignore_p_held", p, 64'd4);

        // Reset during RUN aborts the operation.
        issue(32'h0000FFFF, 32'h0000FFFF, 64'hFFFE0001);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", 64'(ready), 64'd1);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_p", p, 64'd0);
        repeat (40) @(negedge clk);
        issue(32'd7, 32'd6, 64'd42);
        wait_idle("after_abort");

        // rst and start in the same cycle: reset wins.
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        a = 32'd3;
        b = 32'd3;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_over_start_ready", 64'(ready), 64'd1);

        // Back-to-back: start held through DONE with new operands.
        @(negedge clk);
        start = 1'b1;
        a = 32'd5;
        b = 32'd5;
        @(posedge clk);
        #1;
        sb.push_back('{p: 64'd25, due: cyc + lat_of(32'd5) - 1});
        @(negedge clk);
        a = 32'd10;
        b = 32'd10;
        cnt = 0;
        while (done !== 1'b1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        if (done !== 1'b1) fail_now("b2b_first_done", cnt);
        first_done = cyc;
        @(posedge clk);
        #1;
        sb.push_back('{p: 64'd100, due: cyc + lat_of(32'd10) - 1});
        @(negedge clk);
        start = 1'b0;
        wait_idle("b2b_second");
        chk("b2b_spacing", 64'(last_done_cyc - first_done), 64'(lat_of(32'd10)));

        // Random operands with varied multiplier magnitude.
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            issue(ra, rb, 64'(ra) * 64'(rb));
            wait_idle("random_op");
        end

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_seq_mult_ctrl
`default_nettype wire
